// File: rtl/ms_pulse_pair_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ms_pulse_pair_gen                                            |
// | Description : Emits two one-cycle pulses spaced by a programmed number of  |
// |               milliseconds, followed by a one-cycle done strobe. Intended  |
// |               as the transmit side of the ms interval measurement path.    |
// | Option      : RAND_PREDELAY_EN - when defined, a 16-bit Galois LFSR picks  |
// |               a random 1..PRE_MAX_MS ms pre-delay before the first pulse.  |
// |               When undefined, the pre-delay state lasts one cycle.         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module ms_pulse_pair_gen #(
  parameter int CLK_MS_COUNT = 100000,
  parameter int MS_W         = 10,
  parameter int PRE_MAX_MS   = 1023
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            abort,
  input  logic [MS_W-1:0] interval,
  output logic            ready,
  output logic            busy,
  output logic            pulse_out,
  output logic            done,
  output logic [MS_W-1:0] ms_elapsed
);

  // Tick counter width; at least one bit even for degenerate settings.
  localparam int T_W = (CLK_MS_COUNT > 1) ? $clog2(CLK_MS_COUNT) : 1;
  localparam logic [T_W-1:0] T_LAST = T_W'(CLK_MS_COUNT - 1);

  // The P1 cycle doubles as the first gap cycle, so the tick counter needs
  // at least two counts per ms; the LFSR-derived pre-delay is 16 bits wide.
  if (CLK_MS_COUNT < 2 || PRE_MAX_MS < 1 || MS_W > 16) begin : g_param_check
    $error("ms_pulse_pair_gen: need CLK_MS_COUNT>=2, PRE_MAX_MS>=1, MS_W<=16");
  end

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PRE  = 3'd1,
    S_P1   = 3'd2,
    S_GAP  = 3'd3,
    S_P2   = 3'd4,
    S_DONE = 3'd5
  } state_t;

  state_t          state;
  state_t          state_nx;
  logic [T_W-1:0]  t_reg;
  logic [MS_W-1:0] p_reg;
  logic [MS_W-1:0] int_reg;
  logic [MS_W-1:0] ms_reg;

  logic            accept;
  logic            ms_tick;
  logic [MS_W-1:0] p_inc;
  logic            pre_exit;

  assign accept  = (state == S_IDLE) && start;
  assign ms_tick = (t_reg == T_LAST);
  assign p_inc   = p_reg + 1'b1;

`ifdef RAND_PREDELAY_EN
  logic [15:0] lfsr;
  logic [15:0] pre_calc;
  logic [15:0] pre_reg;

  // Free-running Galois LFSR, polynomial x^16 + x^14 + x^13 + x^11 + 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr <= 16'hACE1;
    end else begin
      lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
    end
  end

  assign pre_calc = (lfsr % 16'(PRE_MAX_MS)) + 16'd1;

  // Capture the random pre-delay length at the moment a run is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_reg <= '0;
    end else if (accept) begin
      pre_reg <= pre_calc;
    end
  end

  // PRE leaves one cycle after the last whole pre-delay ms has been counted.
  assign pre_exit = (16'(p_reg) == pre_reg);
`else
  // Without the random pre-delay, PRE is a single-cycle hop.
  assign pre_exit = 1'b1;
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state decode; abort overrides every transition out of a busy state.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (start) state_nx = S_PRE;
      S_PRE:  if (pre_exit) state_nx = S_P1;
      S_P1:   state_nx = S_GAP;
      S_GAP:  if (ms_tick && (p_inc == int_reg)) state_nx = S_P2;
      S_P2:   state_nx = S_DONE;
      S_DONE: state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
    if ((state != S_IDLE) && abort) begin
      state_nx = S_IDLE;
    end
  end

  // Interval latch, tick/ms counters and the live ms_elapsed value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      t_reg   <= '0;
      p_reg   <= '0;
      int_reg <= '0;
      ms_reg  <= '0;
    end else if (accept) begin
      int_reg <= (interval == '0) ? MS_W'(1) : interval;
      t_reg   <= '0;
      p_reg   <= '0;
      ms_reg  <= '0;
    end else begin
      case (state)
        S_PRE: begin
          if (pre_exit) begin
            t_reg <= '0;
            p_reg <= '0;
          end
`ifdef RAND_PREDELAY_EN
          else if (ms_tick) begin
            t_reg <= '0;
            p_reg <= p_inc;
          end else begin
            t_reg <= t_reg + 1'b1;
          end
`endif
        end
        // P1 is counted as the first cycle of the gap so that the second
        // pulse lands exactly int_reg ms after the first one.
        S_P1: t_reg <= t_reg + 1'b1;
        S_GAP: begin
          if (ms_tick) begin
            t_reg  <= '0;
            p_reg  <= p_inc;
            ms_reg <= p_inc;
          end else begin
            t_reg <= t_reg + 1'b1;
          end
        end
        default: begin
          t_reg <= t_reg;
        end
      endcase
    end
  end

  assign ready      = (state == S_IDLE);
  assign busy       = (state != S_IDLE);
  assign pulse_out  = (state == S_P1) || (state == S_P2);
  assign done       = (state == S_DONE);
  assign ms_elapsed = ms_reg;

endmodule
`default_nettype wire

// File: tb/tb_ms_pulse_pair_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_ms_pulse_pair_gen                                         |
// | Description : Scoreboard bench for ms_pulse_pair_gen. The driver queues    |
// |               the expected run outcome; a monitor observes outputs and     |
// |               compares each completed, aborted or reset-killed run.        |
// | Option      : RAND_PREDELAY_EN selects the random pre-delay checks.        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_ms_pulse_pair_gen;

  localparam int C      = 10;
  localparam int MS_W   = 10;
  localparam int PRE_MX = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start = 1'b0;
  logic            abort = 1'b0;
  logic [MS_W-1:0] interval = '0;
  logic            ready;
  logic            busy;
  logic            pulse_out;
  logic            done;
  logic [MS_W-1:0] ms_elapsed;

  ms_pulse_pair_gen #(
    .CLK_MS_COUNT(C),
    .MS_W        (MS_W),
    .PRE_MAX_MS  (PRE_MX)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .interval  (interval),
    .ready     (ready),
    .busy      (busy),
    .pulse_out (pulse_out),
    .done      (done),
    .ms_elapsed(ms_elapsed)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  // kind: 0 = full run, 1 = aborted, 2 = killed by reset
  typedef struct {
    int kind;
    int accept;
    int intv;
    int abort_cyc;
    int ms;
  } exp_t;

  exp_t sbq[$];

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // ---------------- monitor ----------------
  int in_run = 0;
  int orphan = 0;
  int r_start, r_p1, r_p2, r_done, r_pulses;
  int runs_ended = 0;

  task automatic end_run();
    exp_t e;
    int d;
    if (orphan != 0 || sbq.size() == 0) begin
      orphan = 0;
      return;
    end
    e = sbq.pop_front();
    check("accept_cycle", r_start, e.accept);
    check("run_kind", (r_done >= 0) ? 0 : 1, e.kind);
    if (e.kind == 0) begin
`ifdef RAND_PREDELAY_EN
      d = r_p1 - r_start - 1;
      check("pre_whole_ms", d % C, 0);
      check("pre_in_range", ((d >= C) && (d <= PRE_MX * C)) ? 1 : 0, 1);
`else
      d = r_p1 - r_start;
      check("start_to_p1", d, 1);
`endif
      check("p1_to_p2", r_p2 - r_p1, e.intv * C);
      check("p2_to_done", r_done - r_p2, 1);
      check("done_to_ready", cyc - r_done, 1);
      check("pulse_count", r_pulses, 2);
    end else begin
      check("abort_pulse_count", r_pulses, 1);
      check("abort_to_idle", cyc, e.abort_cyc + 1);
    end
    check("ms_elapsed_end", int'(ms_elapsed), e.ms);
  endtask

  // Observe outputs on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (rst) begin
      if (in_run != 0) begin
        if (orphan == 0 && sbq.size() > 0) begin
          exp_t e;
          e = sbq.pop_front();
          check("kill_kind", e.kind, 2);
          check("kill_pulse_count", r_pulses, 1);
          check("kill_no_done", r_done, -1);
        end
        in_run = 0;
        orphan = 0;
        runs_ended++;
      end
    end else begin
      check("busy_is_not_ready", int'(busy), int'(!ready));
      check("outputs_exclusive",
            (int'(pulse_out) + int'(done) + int'(ready) <= 1) ? 1 : 0, 1);
      if (in_run == 0) begin
        if (busy) begin
          in_run   = 1;
          r_start  = cyc;
          r_pulses = 0;
          r_p1     = -1;
          r_p2     = -1;
          r_done   = -1;
          if (sbq.size() == 0) begin
            orphan = 1;
            check("unexpected_start", 1, 0);
          end
          check("ms_cleared_on_accept", int'(ms_elapsed), 0);
        end else if (pulse_out || done) begin
          check("stray_output_in_idle", 1, 0);
        end
      end
      if (in_run != 0) begin
        if (pulse_out) begin
          if (r_pulses == 0) r_p1 = cyc;
          else               r_p2 = cyc;
          r_pulses++;
        end
        if (done) r_done = cyc;
        if (ready) begin
          end_run();
          in_run = 0;
          runs_ended++;
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic wait_ended(input int target, input int budget);
    int k = 0;
    while (runs_ended < target && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("run_finished_in_time", (runs_ended >= target) ? 1 : 0, 1);
  endtask

  task automatic run_one(input int intv, input bit with_abort);
    int tgt;
    int a;
    int eff;
    exp_t e;
    tgt = runs_ended + 1;
    @(negedge clk);
    interval = MS_W'(intv);
    start    = 1'b1;
    abort    = with_abort;
    a        = cyc + 1;
    eff      = (intv == 0) ? 1 : intv;
    e = '{kind: 0, accept: a, intv: eff, abort_cyc: 0, ms: eff};
    sbq.push_back(e);
    @(negedge clk);
    start    = 1'b0;
    abort    = 1'b0;
    interval = MS_W'($urandom);
    // Pokes on start while busy, including the done cycle, must be ignored.
    while (cyc < a + 3 + eff * C) begin
      start = (cyc == a + 2 + eff * C) || ($urandom_range(0, 3) == 0);
      @(negedge clk);
    end
    start = 1'b0;
    wait_ended(tgt, eff * C + PRE_MX * C + 50);
  endtask

  initial begin : watchdog
    #800000;
    $display("FAIL watchdog: simulation exceeded its cycle budget");
    $fatal(1);
  end

  initial begin : stimulus
    int a;
    int a2;
    int tgt;
    exp_t e;

    repeat (3) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    check("reset_ready", int'(ready), 1);
    check("reset_busy", int'(busy), 0);
    check("reset_pulse", int'(pulse_out), 0);
    check("reset_done", int'(done), 0);
    check("reset_ms", int'(ms_elapsed), 0);

    // abort while idle must not start anything
    abort = 1'b1;
    repeat (3) @(negedge clk);
    abort = 1'b0;
    check("abort_in_idle_ready", int'(ready), 1);

    run_one(5, 1'b0);
    run_one(0, 1'b0);
    run_one(1, 1'b1);
    run_one(1023, 1'b0);

`ifndef RAND_PREDELAY_EN
    // start held high across a whole run: the re-accept lands one cycle after done
    tgt = runs_ended + 2;
    @(negedge clk);
    interval = MS_W'(3);
    start    = 1'b1;
    a        = cyc + 1;
    a2       = (a + 2 + 3 * C) + 2;
    e = '{kind: 0, accept: a, intv: 3, abort_cyc: 0, ms: 3};
    sbq.push_back(e);
    e = '{kind: 0, accept: a2, intv: 3, abort_cyc: 0, ms: 3};
    sbq.push_back(e);
    while (cyc < a2) @(negedge clk);
    start = 1'b0;
    wait_ended(tgt, 200);

    // abort seven cycles into the gap
    tgt = runs_ended + 1;
    @(negedge clk);
    interval = MS_W'(4);
    start    = 1'b1;
    a        = cyc + 1;
    e = '{kind: 1, accept: a, intv: 4, abort_cyc: a + 9, ms: 0};
    sbq.push_back(e);
    @(negedge clk);
    start = 1'b0;
    while (cyc < a + 9) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    wait_ended(tgt, 100);

    // reset asserted for three cycles in the middle of the gap
    tgt = runs_ended + 1;
    @(negedge clk);
    interval = MS_W'(5);
    start    = 1'b1;
    a        = cyc + 1;
    e = '{kind: 2, accept: a, intv: 5, abort_cyc: 0, ms: 0};
    sbq.push_back(e);
    @(negedge clk);
    start = 1'b0;
    while (cyc < a + 6) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    check("post_reset_ready", int'(ready), 1);
    check("post_reset_busy", int'(busy), 0);
    check("post_reset_pulse", int'(pulse_out), 0);
    check("post_reset_done", int'(done), 0);
    check("post_reset_ms", int'(ms_elapsed), 0);
    check("reset_run_closed", (runs_ended >= tgt) ? 1 : 0, 1);
    repeat (30) @(negedge clk);
`endif

    for (int i = 0; i < 20; i++) begin
      run_one($urandom_range(0, 12), 1'($urandom_range(0, 1)));
    end

    repeat (10) @(negedge clk);
    check("scoreboard_drained", sbq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
